mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/lc3b_types.sv | 7 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b bus types used by the memory responder and its initiators.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an LC-3b initiator and the memory responder.
interface mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;
    logic          proto_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, proto_err
    );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous byte-masked write, combinational indexed read.
// Deliberately has no reset so contents survive a responder reset.
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  lc3b_mem_wmask        be_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  lc3b_word             wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output lc3b_word             rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [1:0][7:0] mem_q [DEPTH];

    // Byte-lane write; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (be_i[0]) mem_q[waddr_i][0] <= wdata_i[7:0];
            if (be_i[1]) mem_q[waddr_i][1] <= wdata_i[15:8];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures one request in IDLE, waits
// LATENCY cycles in total, pulses mem_resp for one cycle, then commits a
// write at the edge that ends the response cycle.
module mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // WAIT spends LATENCY-2 extra cycles after the one it is entered in.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    lc3b_word               wdata_q, wdata_d;
    lc3b_mem_wmask          be_q, be_d;
    lc3b_word               rdata_q, rdata_d;
    logic                   perr_q, perr_d;

    logic                   req;
    logic [ADDR_BITS-1:0]   in_addr;
    logic [ADDR_BITS-1:0]   raddr;
    lc3b_word               arr_rdata;
    logic                   arr_we;

    assign req     = bus.mem_read | bus.mem_write;
    // Byte address -> word index; upper bits alias.
    assign in_addr = bus.mem_address[ADDR_BITS:1];

    // With LATENCY=1 the read happens on the same edge that captures the
    // request, so the array must see the live address while in IDLE.
    assign raddr   = (state_q == IDLE) ? in_addr : addr_q;
    assign arr_we  = (state_q == RESP) && wr_q;

    mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (be_q),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (raddr),
        .rdata_o (arr_rdata)
    );

    // Next-state, capture and read-data load; everything holds by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    // Read+write together is serviced as a write and flagged.
                    wr_d    = bus.mem_write;
                    addr_d  = in_addr;
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    perr_d  = perr_q | (bus.mem_read & bus.mem_write);
                    cnt_d   = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        if (!bus.mem_write) rdata_d = arr_rdata;
                    end
                end
            end
            WAIT: begin
                // Requests are not re-sampled here: a dropped request still completes.
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!wr_q) rdata_d = arr_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured transaction; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.mem_resp  = (state_q == RESP);
    assign bus.mem_rdata = rdata_q;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: one instance at LATENCY=3, one at
// LATENCY=1, each checked against a word-array reference model.
module tb_mem_responder;
    import lc3b_types::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if ifa ();
    mem_responder_if ifb ();

    mem_responder #(.LATENCY(3), .ADDR_BITS(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int       n_chk = 0;
    int       n_bad = 0;
    lc3b_word mdl [2][256];
    lc3b_word last_rd [2];
    logic     exp_perr [2];
    int       lat_of [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr, input logic [1:0] be,
                         input logic [15:0] a, input logic [15:0] d);
        if (w == 0) begin
            ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_byte_enable = be;
            ifa.mem_address = a; ifa.mem_wdata = d;
        end else begin
            ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_byte_enable = be;
            ifb.mem_address = a; ifb.mem_wdata = d;
        end
    endtask

    function automatic logic resp_of(input int w);
        return (w == 0) ? ifa.mem_resp : ifb.mem_resp;
    endfunction

    function automatic logic [15:0] rdata_of(input int w);
        return (w == 0) ? ifa.mem_rdata : ifb.mem_rdata;
    endfunction

    function automatic logic perr_of(input int w);
        return (w == 0) ? ifa.proto_err : ifb.proto_err;
    endfunction

    // Word index a byte address lands on in a 256-word store.
    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % 256;
    endfunction

    // Entered and left #1 after a rising edge. The request is held until the
    // edge after mem_resp (or dropped after the first edge when drop=1).
    task automatic txn(input int w, input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] a, input logic [15:0] d, input bit drop);
        int  n;
        bit  seen;
        int  idx;
        idx  = widx(a);
        n    = 0;
        seen = 0;
        exp_perr[w] = exp_perr[w] | (rd & wr);
        drive(w, rd, wr, be, a, d);
        while (!seen && n <= 20) begin
            @(negedge clk);
            if (resp_of(w)) seen = 1;
            else begin
                n++;
                @(posedge clk); #1;
                if (drop) drive(w, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
            end
        end
        chk("resp_latency", seen ? n : 999, lat_of[w]);
        if (wr) begin
            chk("wr_keeps_rdata", rdata_of(w), last_rd[w]);
        end else begin
            chk("rd_data", rdata_of(w), mdl[w][idx]);
            last_rd[w] = mdl[w][idx];
        end
        chk("proto_err", perr_of(w), exp_perr[w]);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        if (wr) begin
            if (be[0]) mdl[w][idx][7:0]  = d[7:0];
            if (be[1]) mdl[w][idx][15:8] = d[15:8];
        end
    endtask

    task automatic idle(input int w, input int k);
        repeat (k) begin
            @(negedge clk);
            chk("idle_no_resp", resp_of(w), 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk({tag, "_resp"},  resp_of(w),  1'b0);
            chk({tag, "_rdata"}, rdata_of(w), 16'h0000);
            chk({tag, "_perr"},  perr_of(w),  1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        logic [1:0]  be;
        int          r;
        lat_of[0] = 3;
        lat_of[1] = 1;
        for (int w = 0; w < 2; w++) begin
            last_rd[w]  = 16'h0;
            exp_perr[w] = 1'b0;
            drive(w, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        end

        // Reset
        #2 rst_n = 1'b0;
        #20;
        chk_reset_outs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill both stores with random words through the bus
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++)
                txn(w, 1'b0, 1'b1, 2'b11, 16'(i * 2), 16'($urandom), 1'b0);

        // Read of a preloaded word, latency 3
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0);
        idle(0, 2);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, 1'b0);
        chk("beef", ifa.mem_rdata, 16'hBEEF);

        // Byte-lane writes
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'hAAAA, 1'b0);
        txn(0, 1'b0, 1'b1, 2'b01, 16'h0020, 16'h1234, 1'b0);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0, 1'b0);
        chk("be01", ifa.mem_rdata, 16'hAA34);
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'hAAAA, 1'b0);
        txn(0, 1'b0, 1'b1, 2'b10, 16'h0020, 16'h1234, 1'b0);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0, 1'b0);
        chk("be10", ifa.mem_rdata, 16'h12AA);
        txn(0, 1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, 1'b0);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0, 1'b0);
        chk("be00", ifa.mem_rdata, 16'h12AA);

        // Back-to-back reads, each held through its response cycle
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, 1'b0);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0, 1'b0);
        idle(0, 2);

        // Read and write together: write wins, proto_err sticks
        txn(0, 1'b1, 1'b1, 2'b11, 16'h0002, 16'h5555, 1'b0);
        chk("perr_set", ifa.proto_err, 1'b1);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0, 1'b0);
        chk("perr_rd", ifa.mem_rdata, 16'h5555);
        chk("perr_sticky", ifa.proto_err, 1'b1);

        // Reset during WAIT of a write: transaction is discarded
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h1357, 1'b0);
        drive(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'hFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_no_resp", ifa.mem_resp, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            last_rd[w]  = 16'h0;
            exp_perr[w] = 1'b0;
        end
        idle(0, 4);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0, 1'b0);
        chk("rst_old", ifa.mem_rdata, 16'h1357);

        // Latency 1 with address aliasing
        txn(1, 1'b0, 1'b1, 2'b11, 16'h0202, 16'h0BAD, 1'b0);
        txn(1, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0, 1'b0);
        chk("alias", ifb.mem_rdata, 16'h0BAD);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            int w;
            w  = (i % 3 == 0) ? 1 : 0;
            r  = $urandom_range(0, 19);
            a  = 16'($urandom);
            d  = 16'($urandom);
            be = 2'($urandom);
            if (r == 0)      txn(w, 1'b1, 1'b1, be, a, d, 1'b0);
            else if (r < 9)  txn(w, 1'b1, 1'b0, be, a, d, r < 3);
            else             txn(w, 1'b0, 1'b1, be, a, d, r > 16);
            if ($urandom_range(0, 2) == 0) idle(w, $urandom_range(1, 2));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
